objects_mux_collision: RTL and testbench
========================================

Name: objects_mux_collision

Overview:
- Consumer end of the bitmap draw interface: takes each object renderer's drawingRequest/RGBout pair, composites one VGA pixel by fixed priority, and detects pixel-overlap collisions per frame.
- Closes the loop back to the player renderer by driving its blink and visible inputs from a hit/invulnerability/lives state machine.
- Sits between the object bitmaps and the VGA controller.

Parameters:
- NUM_BALLS, 4, number of ball renderers on the bus.
- LIVES, 3, player lives at reset.
- INVULN_FRAMES, 120, frames of invulnerability after an accepted hit.
- BLINK_PERIOD, 8, frames per blink half-period during invulnerability.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at start of each frame.
- playerDR  in  1  player draw request.
- playerRGB  in  8  player pixel colour.
- ropeDR  in  1  rope draw request.
- ropeRGB  in  8  rope pixel colour.
- ballDR  in  NUM_BALLS  ball draw requests; bit i is ball i.
- ballRGB  in  8*NUM_BALLS  ball colours; ball i in bits [8i+7:8i].
- bgRGB  in  8  background colour.
- RGBout  out  8  composited pixel to VGA.
- playerHit  out  1  one-cycle pulse when a hit is accepted.
- ballRopeHit  out  NUM_BALLS  one-cycle pulse per ball hit by the rope in the previous frame.
- playerBlink  out  1  to the player renderer's blink input.
- playerVisible  out  1  to the player renderer's visible input.
- gameOver  out  1  level; high when lives are exhausted.
- livesLeft  out  2  remaining lives.

Behaviour:
- Reset values:
  - RGBout=8'h00; playerHit=0; ballRopeHit=0.
  - playerBlink=0; playerVisible=1; gameOver=0.
  - livesLeft=LIVES; state NORMAL; all accumulators cleared.
- Compositing priority: player > rope > ball 0 > … > ball NUM_BALLS-1 > bgRGB.
  - RGBout is registered: one clock latency from the inputs.
- Collision accumulators (sticky within a frame):
  - playerBallAcc sets on any cycle with playerDR & |ballDR.
  - ropeBallAcc[i] sets on ropeDR & ballDR[i].
- On startOfFrame:
  - Accumulator contents are transferred to the pulse logic, then cleared.
  - An overlap in the same cycle as startOfFrame belongs to the new frame: it is written into the cleared accumulator.
- ballRopeHit[i] pulses for exactly one cycle, the cycle after startOfFrame, when ropeBallAcc[i] was set. Each ball is reported independently.
- State machine (advances only on startOfFrame, except reset):
  - NORMAL: if playerBallAcc was set, then playerHit pulses one cycle and livesLeft decrements.
    - livesLeft becomes 0 → DEAD.
    - Otherwise → INVULN with frameCnt=0.
  - INVULN: playerBallAcc is ignored (no pulse, no decrement). frameCnt increments each frame.
    - playerBlink toggles every BLINK_PERIOD frames, starting at 1 on entry.
    - frameCnt==INVULN_FRAMES-1 → NORMAL with playerBlink=0.
  - DEAD: playerVisible=0, gameOver=1, playerBlink=0. Terminal until reset.
- livesLeft saturates at 0 and never wraps.
- Reset mid-frame or mid-INVULN returns every output to its reset value immediately; the accumulators clear asynchronously.
- In DEAD, playerDR still participates in compositing. The player renderer blanks itself because playerVisible=0.

Optional Feature:
- Macro OBJMUX_DEBUG_COLLISION_EN.
- Defined: any cycle with playerDR & |ballDR, or ropeDR & |ballDR, forces RGBout=8'hE0 (red) in place of the composited colour, with the same one-cycle latency. Collision logic is unchanged.
- Undefined: no override; compositing is pure priority.

Test Plan:
- Reset with all DR=0, bgRGB=8'h1C → RGBout=8'h00 during reset, then 8'h1C one cycle after release; livesLeft=3, playerVisible=1.
- playerDR=1/playerRGB=8'h6D together with ballDR[2]=1/ballRGB[2]=8'hE0 → RGBout=8'h6D one cycle later; at the next startOfFrame playerHit pulses once, livesLeft=2, playerBlink=1.
- Continued overlap during the 120 INVULN frames → no playerHit and livesLeft stays 2; playerBlink toggles every 8 frames; after frame 120 it returns to NORMAL with playerBlink=0.
- ropeDR with ballDR[0] and ballDR[3] in one frame → ballRopeHit=4'b1001 for exactly one cycle after startOfFrame, and 4'b0000 the next frame if there is no overlap.
- Three accepted hits separated by INVULN windows → livesLeft=0, gameOver=1, playerVisible=0; a further overlap changes nothing.
- Overlap in the same cycle as startOfFrame → reported at the following startOfFrame, not the current one; with OBJMUX_DEBUG_COLLISION_EN defined, RGBout=8'hE0 on that overlap cycle plus one.

Source files
------------

// File: rtl/objects_mux_collision.sv
// Pixel compositor and per-frame collision tracker sitting between the object renderers and the VGA controller.
// Define OBJMUX_DEBUG_COLLISION_EN to paint overlap pixels red (8'hE0) instead of the composited colour.
module objects_mux_collision #(
   parameter int NUM_BALLS     = 4,
   parameter int LIVES         = 3,
   parameter int INVULN_FRAMES = 120,
   parameter int BLINK_PERIOD  = 8
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startOfFrame,
   input  logic                   playerDR,
   input  logic [7:0]             playerRGB,
   input  logic                   ropeDR,
   input  logic [7:0]             ropeRGB,
   input  logic [NUM_BALLS-1:0]   ballDR,
   input  logic [8*NUM_BALLS-1:0] ballRGB,
   input  logic [7:0]             bgRGB,
   output logic [7:0]             RGBout,
   output logic                   playerHit,
   output logic [NUM_BALLS-1:0]   ballRopeHit,
   output logic                   playerBlink,
   output logic                   playerVisible,
   output logic                   gameOver,
   output logic [1:0]             livesLeft
);

   localparam int FCW = $clog2(INVULN_FRAMES + 1);
   localparam int BCW = $clog2(BLINK_PERIOD + 1);
   localparam logic [FCW-1:0] LAST_FRAME = FCW'(INVULN_FRAMES - 1);
   localparam logic [BCW-1:0] LAST_BLINK = BCW'(BLINK_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_NORMAL,
      ST_INVULN,
      ST_DEAD
   } state_t;

   state_t                 state_q, state_d;
   logic [7:0]             rgb_q, rgb_d;
   logic [7:0]             rgb_mux;
   logic                   player_ball_acc_q, player_ball_acc_d;
   logic [NUM_BALLS-1:0]   rope_ball_acc_q, rope_ball_acc_d;
   logic [NUM_BALLS-1:0]   ball_rope_hit_q, ball_rope_hit_d;
   logic                   hit_q, hit_d;
   logic                   blink_q, blink_d;
   logic [1:0]             lives_q, lives_d;
   logic [FCW-1:0]         frame_cnt_q, frame_cnt_d;
   logic [BCW-1:0]         blink_cnt_q, blink_cnt_d;
   logic                   player_ball_ovl;
   logic [NUM_BALLS-1:0]   rope_ball_ovl;

   // Lowest-indexed ball wins, so scan from the highest index down.
   always_comb begin
      rgb_mux = bgRGB;
      for (int i = NUM_BALLS - 1; i >= 0; i--) begin
         if (ballDR[i]) rgb_mux = ballRGB[8*i +: 8];
      end
      if (ropeDR)   rgb_mux = ropeRGB;
      if (playerDR) rgb_mux = playerRGB;
   end

   assign player_ball_ovl = playerDR & (|ballDR);
   assign rope_ball_ovl   = {NUM_BALLS{ropeDR}} & ballDR;

   always_comb begin
      rgb_d = rgb_mux;
`ifdef OBJMUX_DEBUG_COLLISION_EN
      if (player_ball_ovl | (ropeDR & (|ballDR))) rgb_d = 8'hE0;
`endif
   end

   // An overlap on the startOfFrame cycle seeds the freshly cleared accumulator.
   always_comb begin
      player_ball_acc_d = player_ball_acc_q | player_ball_ovl;
      rope_ball_acc_d   = rope_ball_acc_q | rope_ball_ovl;
      ball_rope_hit_d   = '0;
      if (startOfFrame) begin
         player_ball_acc_d = player_ball_ovl;
         rope_ball_acc_d   = rope_ball_ovl;
         ball_rope_hit_d   = rope_ball_acc_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      frame_cnt_d = frame_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
      hit_d       = 1'b0;
      if (startOfFrame) begin
         case (state_q)
            ST_NORMAL: begin
               if (player_ball_acc_q) begin
                  hit_d = 1'b1;
                  if (lives_q <= 2'd1) begin
                     lives_d = 2'd0;
                     state_d = ST_DEAD;
                     blink_d = 1'b0;
                  end else begin
                     lives_d     = lives_q - 2'd1;
                     state_d     = ST_INVULN;
                     frame_cnt_d = '0;
                     blink_cnt_d = '0;
                     blink_d     = 1'b1;
                  end
               end
            end
            ST_INVULN: begin
               if (frame_cnt_q == LAST_FRAME) begin
                  state_d = ST_NORMAL;
                  blink_d = 1'b0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
                  if (blink_cnt_q == LAST_BLINK) begin
                     blink_cnt_d = '0;
                     blink_d     = ~blink_q;
                  end else begin
                     blink_cnt_d = blink_cnt_q + 1'b1;
                  end
               end
            end
            ST_DEAD: begin
               blink_d = 1'b0;
            end
            default: begin
               state_d = ST_NORMAL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q           <= ST_NORMAL;
         rgb_q             <= 8'h00;
         player_ball_acc_q <= 1'b0;
         rope_ball_acc_q   <= '0;
         ball_rope_hit_q   <= '0;
         hit_q             <= 1'b0;
         blink_q           <= 1'b0;
         lives_q           <= 2'(LIVES);
         frame_cnt_q       <= '0;
         blink_cnt_q       <= '0;
      end else begin
         state_q           <= state_d;
         rgb_q             <= rgb_d;
         player_ball_acc_q <= player_ball_acc_d;
         rope_ball_acc_q   <= rope_ball_acc_d;
         ball_rope_hit_q   <= ball_rope_hit_d;
         hit_q             <= hit_d;
         blink_q           <= blink_d;
         lives_q           <= lives_d;
         frame_cnt_q       <= frame_cnt_d;
         blink_cnt_q       <= blink_cnt_d;
      end
   end

   assign RGBout        = rgb_q;
   assign playerHit     = hit_q;
   assign ballRopeHit   = ball_rope_hit_q;
   assign playerBlink   = blink_q;
   assign playerVisible = (state_q != ST_DEAD);
   assign gameOver      = (state_q == ST_DEAD);
   assign livesLeft     = lives_q;

endmodule

// File: tb/tb_objects_mux_collision.sv
// Directed bench for objects_mux_collision: compositing priority, frame-aligned collision pulses,
// invulnerability/blink timing, lives exhaustion and asynchronous reset.
module tb_objects_mux_collision;

   logic        clk;
   logic        resetN;
   logic        startOfFrame;
   logic        playerDR;
   logic [7:0]  playerRGB;
   logic        ropeDR;
   logic [7:0]  ropeRGB;
   logic [3:0]  ballDR;
   logic [31:0] ballRGB;
   logic [7:0]  bgRGB;
   logic [7:0]  RGBout;
   logic        playerHit;
   logic [3:0]  ballRopeHit;
   logic        playerBlink;
   logic        playerVisible;
   logic        gameOver;
   logic [1:0]  livesLeft;

   int compareCount = 0;
   int errCount     = 0;

   objects_mux_collision dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (startOfFrame),
      .playerDR     (playerDR),
      .playerRGB    (playerRGB),
      .ropeDR       (ropeDR),
      .ropeRGB      (ropeRGB),
      .ballDR       (ballDR),
      .ballRGB      (ballRGB),
      .bgRGB        (bgRGB),
      .RGBout       (RGBout),
      .playerHit    (playerHit),
      .ballRopeHit  (ballRopeHit),
      .playerBlink  (playerBlink),
      .playerVisible(playerVisible),
      .gameOver     (gameOver),
      .livesLeft    (livesLeft)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic pdr, input logic rdr, input logic [3:0] bdr, input logic sof);
      playerDR     = pdr;
      ropeDR       = rdr;
      ballDR       = bdr;
      startOfFrame = sof;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         errCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One frame: optional player/ball2 overlap cycle, an idle cycle, then the startOfFrame cycle.
   task automatic runFrame(input logic overlap);
      applyStimulus(overlap, 1'b0, overlap ? 4'b0100 : 4'b0000, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
   endtask

   initial begin
      resetN    = 1'b0;
      playerRGB = 8'h6D;
      ropeRGB   = 8'h92;
      ballRGB   = {8'h44, 8'hE0, 8'h22, 8'h11};
      bgRGB     = 8'h1C;
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
      repeat (2) stepCycle();

      checkOutput("rst_rgb",     32'(RGBout),        32'h00);
      checkOutput("rst_lives",   32'(livesLeft),     32'd3);
      checkOutput("rst_visible", 32'(playerVisible), 32'd1);
      checkOutput("rst_blink",   32'(playerBlink),   32'd0);
      checkOutput("rst_over",    32'(gameOver),      32'd0);
      checkOutput("rst_hit",     32'(playerHit),     32'd0);
      checkOutput("rst_brhit",   32'(ballRopeHit),   32'd0);

      resetN = 1'b1;
      stepCycle();
      checkOutput("bg_after_rst", 32'(RGBout), 32'h1C);

      applyStimulus(1'b0, 1'b0, 4'b1100, 1'b0);
      stepCycle();
      checkOutput("prio_ball2_over_ball3", 32'(RGBout), 32'hE0);
      applyStimulus(1'b0, 1'b0, 4'b1000, 1'b0);
      stepCycle();
      checkOutput("prio_ball3_only", 32'(RGBout), 32'h44);
      applyStimulus(1'b0, 1'b0, 4'b0011, 1'b0);
      stepCycle();
      checkOutput("prio_ball0_over_ball1", 32'(RGBout), 32'h11);

      applyStimulus(1'b1, 1'b0, 4'b0100, 1'b0);
      stepCycle();
`ifdef OBJMUX_DEBUG_COLLISION_EN
      checkOutput("prio_player_over_ball2", 32'(RGBout), 32'hE0);
`else
      checkOutput("prio_player_over_ball2", 32'(RGBout), 32'h6D);
`endif
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
      stepCycle();
      checkOutput("hit_before_sof", 32'(playerHit), 32'd0);
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
      checkOutput("hit1_pulse", 32'(playerHit),   32'd1);
      checkOutput("hit1_lives", 32'(livesLeft),   32'd2);
      checkOutput("hit1_blink", 32'(playerBlink), 32'd1);
      checkOutput("hit1_brhit", 32'(ballRopeHit), 32'd0);
      stepCycle();
      checkOutput("hit1_pulse_end", 32'(playerHit), 32'd0);

      for (int k = 1; k <= 120; k++) begin
         runFrame(1'b1);
         checkOutput("invuln_no_hit", 32'(playerHit), 32'd0);
         checkOutput("invuln_lives",  32'(livesLeft), 32'd2);
         if (k < 120) checkOutput("invuln_blink", 32'(playerBlink), 32'(((k / 8) % 2) == 0));
         else         checkOutput("invuln_exit_blink", 32'(playerBlink), 32'd0);
      end
      runFrame(1'b0);
      checkOutput("normal_quiet_hit",   32'(playerHit), 32'd0);
      checkOutput("normal_quiet_lives", 32'(livesLeft), 32'd2);

      applyStimulus(1'b0, 1'b1, 4'b1001, 1'b0);
      stepCycle();
`ifdef OBJMUX_DEBUG_COLLISION_EN
      checkOutput("prio_rope_over_ball0", 32'(RGBout), 32'hE0);
`else
      checkOutput("prio_rope_over_ball0", 32'(RGBout), 32'h92);
`endif
      applyStimulus(1'b0, 1'b0, 4'b0110, 1'b0);
      stepCycle();
      checkOutput("prio_ball1_over_ball2", 32'(RGBout), 32'h22);
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
      checkOutput("rope_brhit_pulse", 32'(ballRopeHit), 32'b1001);
      checkOutput("rope_no_player",   32'(playerHit),   32'd0);
      stepCycle();
      checkOutput("rope_brhit_end", 32'(ballRopeHit), 32'b0000);
      runFrame(1'b0);
      checkOutput("rope_next_frame_clear", 32'(ballRopeHit), 32'b0000);

      applyStimulus(1'b1, 1'b1, 4'b0001, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
`ifdef OBJMUX_DEBUG_COLLISION_EN
      checkOutput("sof_ovl_rgb", 32'(RGBout), 32'hE0);
`else
      checkOutput("sof_ovl_rgb", 32'(RGBout), 32'h6D);
`endif
      checkOutput("sof_ovl_not_now_hit",   32'(playerHit),   32'd0);
      checkOutput("sof_ovl_not_now_lives", 32'(livesLeft),   32'd2);
      checkOutput("sof_ovl_not_now_brhit", 32'(ballRopeHit), 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
      checkOutput("sof_ovl_next_hit",   32'(playerHit),   32'd1);
      checkOutput("sof_ovl_next_lives", 32'(livesLeft),   32'd1);
      checkOutput("sof_ovl_next_brhit", 32'(ballRopeHit), 32'b0001);
      checkOutput("sof_ovl_next_blink", 32'(playerBlink), 32'd1);

      for (int k = 1; k <= 119; k++) runFrame(1'b0);
      checkOutput("invuln2_last_blink", 32'(playerBlink), 32'd1);
      checkOutput("invuln2_lives",      32'(livesLeft),   32'd1);
      runFrame(1'b1);
      checkOutput("invuln2_exit_hit",   32'(playerHit),   32'd0);
      checkOutput("invuln2_exit_blink", 32'(playerBlink), 32'd0);
      runFrame(1'b1);
      checkOutput("hit3_pulse",   32'(playerHit),     32'd1);
      checkOutput("hit3_lives",   32'(livesLeft),     32'd0);
      checkOutput("hit3_over",    32'(gameOver),      32'd1);
      checkOutput("hit3_visible", 32'(playerVisible), 32'd0);
      checkOutput("hit3_blink",   32'(playerBlink),   32'd0);

      runFrame(1'b1);
      checkOutput("dead_no_hit",  32'(playerHit),     32'd0);
      checkOutput("dead_lives",   32'(livesLeft),     32'd0);
      checkOutput("dead_over",    32'(gameOver),      32'd1);
      checkOutput("dead_visible", 32'(playerVisible), 32'd0);
      applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
      stepCycle();
      checkOutput("dead_player_rgb", 32'(RGBout), 32'h6D);

      applyStimulus(1'b1, 1'b1, 4'b0001, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
      #2 resetN = 1'b0;
      #1;
      checkOutput("midrst_lives",   32'(livesLeft),     32'd3);
      checkOutput("midrst_over",    32'(gameOver),      32'd0);
      checkOutput("midrst_visible", 32'(playerVisible), 32'd1);
      checkOutput("midrst_rgb",     32'(RGBout),        32'h00);
      stepCycle();
      resetN = 1'b1;
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
      checkOutput("midrst_acc_hit",   32'(playerHit),   32'd0);
      checkOutput("midrst_acc_brhit", 32'(ballRopeHit), 32'd0);

      runFrame(1'b1);
      checkOutput("rehit_lives", 32'(livesLeft),   32'd2);
      checkOutput("rehit_blink", 32'(playerBlink), 32'd1);
      #2 resetN = 1'b0;
      #1;
      checkOutput("invrst_blink", 32'(playerBlink), 32'd0);
      checkOutput("invrst_lives", 32'(livesLeft),   32'd3);
      stepCycle();
      resetN = 1'b1;
      stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
      $finish;
   end

endmodule
